serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial adder controller. It time-shares a single 1-bit full-adder cell
//   (sum = A^B^C, carry = AB|BC|AC) to add two WIDTH-bit operands plus a
//   carry-in, one bit per clock, LSB first.
//   It owns the sequencing FSM, the operand shift registers, the carry
//   flip-flop, the bit counter and the start/done handshake.
//   It is the multi-bit front end for the full-adder datapath cell.
//
// PARAMETERS
//   WIDTH   8   operand width in bits; legal range 1..32
//
// PORTS
//   clk     in   1      rising-edge clock; the only clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  operand A; captured on the accepting edge
//   b       in   WIDTH  operand B; captured on the accepting edge
//   cin     in   1      carry-in; captured on the accepting edge
//   busy    out  1      high while state == RUN
//   done    out  1      one-cycle pulse: result valid
//   sum     out  WIDTH  registered result; held until the next completion
//   cout    out  1      registered carry-out; held with sum
//
// BEHAVIOUR
//   Reset
//   - rst=1 forces state IDLE and clears all registers immediately.
//   - While in reset, busy=0, done=0, sum=0 and cout=0.
//
//   States
//   - IDLE: start=1 -> RUN. Load shift regs with a and b, carry FF with cin,
//     bit counter with 0.
//   - RUN: every edge does one full-adder step on the LSBs and carry FF.
//     - The sum bit shifts into the MSB of the internal sum shift register.
//     - The operand shift regs shift right and the carry FF updates.
//     - The counter increments by 1.
//     - On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
//       copy the sum shift reg (including this bit) to sum, copy the
//       final carry to cout, and move to DONE.
//   - DONE: done=1 for exactly this cycle.
//     - start=1 -> RUN, with a new load exactly as from IDLE.
//     - start=0 -> IDLE.
//
//   Handshake and latency
//   - The start accept edge is E0.
//   - Bits are processed on edges E1..E_WIDTH.
//   - sum, cout and done all update at E_WIDTH; done is high for the
//     E_WIDTH..E_WIDTH+1 cycle.
//   - Throughput is one add per WIDTH+1 cycles.
//   - start while busy=1 is ignored. The operation in flight is unaffected,
//     and a/b/cin may change freely during RUN.
//
//   Outputs
//   - sum and cout never show partial values. They change only at a
//     completion edge or at reset.
//
//   Arithmetic
//   - {cout,sum} == a + b + cin, as a (WIDTH+1)-bit result with no overflow
//     loss.
//   - The counter is $clog2(WIDTH+1) bits wide.
//   - WIDTH=1: RUN lasts exactly one edge.
//
//   Reset mid-operation
//   - The operation aborts with no done pulse and sum/cout cleared.
//   - After rst falls, the block is in IDLE and accepts a new start on the
//     next edge.
//
// TESTING
//   1. Reset:
//      - assert rst between edges -> busy/done/sum/cout = 0 immediately.
//   2. WIDTH=8, a=8'hFF, b=8'h01, cin=0, start for 1 cycle at E0:
//      - busy=1 on E1..E7.
//      - done=1 only after E8.
//      - sum=8'h00, cout=1.
//   3. a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
//      a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
//   4. Start while busy:
//      - pulse start with a=8'h11 mid-RUN -> ignored.
//      - The first result is unchanged and there is exactly one done pulse.
//   5. Back-to-back:
//      - hold start=1 with new operands during the DONE cycle -> next done
//        comes 9 cycles after the first.
//      - sum is held between the two done pulses.
//   6. rst pulse at E4 of an operation:
//      - no done; sum=0.
//      - A new start after reset yields the correct result.
//      - Then run 200 random a/b/cin against the a+b+cin model
//        (also run with WIDTH=1).

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one shared 1-bit full-adder cell across
// WIDTH clocks, LSB first, and produces {cout,sum} = a + b + cin with a
// start/done handshake.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  // Operand A register doubles as the sum shift register: each step consumes
  // bit 0 of A and the new sum bit enters at the MSB, so after WIDTH steps it
  // holds the complete sum.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_a_next;

  // Shared full-adder cell on the operand LSBs and the carry flip-flop
  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    w_c    = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_a[0] & r_carry);
    w_last = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Shift A right with the fresh sum bit entering at the MSB
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_s;
    end else begin : g_wn
      assign w_a_next = {w_s, r_a[WIDTH-1:1]};
    end
  endgenerate

  // Sequencing FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum   <= w_a_next;
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance with directed
// and random vectors, and a 1-bit instance run alongside.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         rst1, start1, cin1, a1, b1;
  logic         busy1, done1, sum1, cout1;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_done1 = 0;
  logic w1_fin = 1'b0;

  logic [W:0] exp_q[$];
  logic [1:0] exp1_q[$];
  logic [W:0] mon_last = '0;
  logic [1:0] mon1_last = '0;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: pop on done, otherwise outputs must hold
  always @(negedge clk) begin
    if (rst) begin
      mon_last = '0;
    end else if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(n_done), 32'(0));
      end else begin
        mon_last = exp_q.pop_front();
        check("result", 32'({cout, sum}), 32'(mon_last));
      end
    end else begin
      check("hold", 32'({cout, sum}), 32'(mon_last));
    end
  end

  // Monitor for the 1-bit instance
  always @(negedge clk) begin
    if (rst1) begin
      mon1_last = '0;
    end else if (done1) begin
      n_done1++;
      if (exp1_q.size() == 0) begin
        check("w1_unexpected_done", 32'(n_done1), 32'(0));
      end else begin
        mon1_last = exp1_q.pop_front();
        check("w1_result", 32'({cout1, sum1}), 32'(mon1_last));
      end
    end else begin
      check("w1_hold", 32'({cout1, sum1}), 32'(mon1_last));
    end
  end

  // Issue one start pulse; expected value is pushed by the caller
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(posedge clk); #1;
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done to be seen at a falling edge
  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 40) check(name, 32'(0), 32'(1));
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W:0] expv);
    exp_q.push_back(expv);
    issue(ia, ib, ic);
    wait_done("op_timeout");
  endtask

  // 1-bit instance: exhaustive then random, checking single-edge RUN
  initial begin
    logic [2:0] v;
    rst1 = 1'b1; start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    for (int i = 0; i < 58; i++) begin
      v = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
      exp1_q.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      @(posedge clk); #1;
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      if (i < 2) check("w1_busy_after_e0", 32'(busy1), 32'(1));
      @(posedge clk); #1;
      if (i < 2) begin
        check("w1_done_at_e1", 32'(done1), 32'(1));
        check("w1_busy_at_e1", 32'(busy1), 32'(0));
      end
    end
    repeat (3) @(posedge clk);
    w1_fin = 1'b1;
  end

  initial begin
    int cyc;
    int d0;
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_sumcout", 32'({cout, sum}), 32'(0));
    rst = 1'b0;

    // FF + 01: latency and busy profile
    exp_q.push_back(9'h100);
    issue(8'hFF, 8'h01, 1'b0);
    check("busy_e0", 32'(busy), 32'(1));
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check("busy_run", 32'(busy), 32'(1));
      check("no_early_done", 32'(done), 32'(0));
    end
    @(posedge clk); #1;
    check("done_e8", 32'(done), 32'(1));
    check("busy_e8", 32'(busy), 32'(0));
    check("sum_e8", 32'({cout, sum}), 32'(9'h100));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'(0));

    // Carry-in only, and carry chain through all bits
    run_op(8'h00, 8'h00, 1'b1, 9'h001);
    run_op(8'hA5, 8'h5A, 1'b1, 9'h100);

    // Reset asserted between edges clears outputs at once
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async_rst_sumcout", 32'({cout, sum}), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Start pulse mid-RUN is ignored
    d0 = n_done;
    exp_q.push_back(9'h04B);
    issue(8'h3C, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1 a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("single_done_pulse", 32'(n_done - d0), 32'(1));

    // Back-to-back: start held during DONE cycle
    exp_q.push_back(9'h046);
    issue(8'h12, 8'h34, 1'b0);
    wait_done("b2b_first_timeout");
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    exp_q.push_back(9'h101);
    cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) start = 1'b0;
      if (done) break;
    end
    check("b2b_spacing", 32'(cyc), 32'(9));

    // Reset at E4 aborts the operation
    @(posedge clk); #1;
    d0 = n_done;
    issue(8'h77, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_sumcout", 32'({cout, sum}), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("abort_no_done", 32'(n_done - d0), 32'(0));
    check("abort_sum_zero", 32'({cout, sum}), 32'(0));
    run_op(8'h77, 8'h22, 1'b0, 9'h099);

    // Random vectors against a + b + cin
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end

    for (int k = 0; k < 5000 && !w1_fin; k++) @(posedge clk);
    check("w1_finished", 32'(w1_fin), 32'(1));
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("w1_queue_drained", 32'(exp1_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
